// File: rtl/adpll_cfg_seq_if.sv
// Host-side bus for adpll_cfg_seq.
//   start   : request a full programming sequence
//   wr_en   : shadow register write strobe
//   wr_addr : shadow index (0 ndiv .. 5 kdco, 6 alpha_gear, 7 beta_gear)
//   wr_data : shadow write data
//   busy    : sequence in progress
//   done    : one-cycle pulse at the end of any sequence
//   err     : one-cycle pulse on a rejected write
// master = host that drives the requests, slave = the sequencer.
interface adpll_cfg_seq_if;
    logic       start;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic       busy;
    logic       done;
    logic       err;

    modport master (output start, wr_en, wr_addr, wr_data, input busy, done, err);
    modport slave  (input start, wr_en, wr_addr, wr_data, output busy, done, err);
endinterface

// File: rtl/adpll_cfg_seq.sv
// adpll_cfg_seq: programming sequencer for the 5-bit ADPLL chip top.
// Keeps a shadow copy of the loop parameters and replays them onto the chip's
// clr / pgm / param_sel / pgm_value pins with fixed setup, pulse and hold
// spacing so the chip's enable-edge capture registers latch stable data.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   host         adpll_cfg_seq_if.slave (start, shadow writes, busy/done/err)
//   lock_i       loop lock indication (level), used only with CFG_GEAR_EN
//   gear_on_o    post-lock alpha/beta currently programmed
//   clr_o        chip clr
//   pgm_o        chip pgm
//   param_sel_o  chip param_sel
//   pgm_value_o  chip pgm_value
//
// Optional feature macro: CFG_GEAR_EN (gear shift of alpha/beta after lock).
//
// state   | meaning
// IDLE    | waiting for start, chip pins parked at 0
// CLEAR   | clr high before the first parameter
// SETUP   | sel/value presented, pgm low
// PULSE   | pgm high
// HOLD    | pgm low, sel/value still held
// DONE    | one-cycle done pulse
// MONITOR | (gear) counting consecutive lock cycles
// LOCKED  | (gear) gear coefficients active, watching for lock loss
module adpll_cfg_seq #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CLR_CYC   = 2,
    parameter int LOCK_CNT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    adpll_cfg_seq_if.slave        host,
    input  logic                  lock_i,
    output logic                  gear_on_o,
    output logic                  clr_o,
    output logic                  pgm_o,
    output logic [2:0]            param_sel_o,
    output logic [4:0]            pgm_value_o
);

    // A zero count would collapse a phase, so every phase lasts at least one cycle.
    localparam int S_CYC = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
    localparam int P_CYC = (PULSE_CYC < 1) ? 1 : PULSE_CYC;
    localparam int H_CYC = (HOLD_CYC  < 1) ? 1 : HOLD_CYC;
    localparam int C_CYC = (CLR_CYC   < 1) ? 1 : CLR_CYC;

    // Down-counter load values: a phase of N cycles loads N-1 and exits at 0.
    localparam logic [7:0] S_LD = 8'(S_CYC - 1);
    localparam logic [7:0] P_LD = 8'(P_CYC - 1);
    localparam logic [7:0] H_LD = 8'(H_CYC - 1);
    localparam logic [7:0] C_LD = 8'(C_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_DONE
`ifdef CFG_GEAR_EN
        , ST_MONITOR
        , ST_LOCKED
`endif
    } state_t;

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [2:0] idx_q;
    logic       short_q;     // current sequence is the alpha/beta-only one
    logic       gear_seq_q;  // short sequence loads the gear coefficients
    logic       busy_q;
    logic       done_q;
    logic       err_q;
    logic       gear_q;
    logic       clr_q;
    logic       pgm_q;
    logic [2:0] sel_q;
    logic [4:0] val_q;
    logic [4:0] shadow_q [8];

    logic       addr_ok;
    logic       wr_ok;
    logic       go_full;
    logic       go_short;
    logic       short_gear;

`ifdef CFG_GEAR_EN
    localparam logic [16:0] LOCK_TGT = 17'(LOCK_CNT);
    logic [15:0] lock_cnt_q;
    logic        lock_hit;
    assign lock_hit = ({1'b0, lock_cnt_q} + 17'd1) >= LOCK_TGT;
    assign addr_ok  = 1'b1;
`else
    logic unused_lock;
    assign unused_lock = lock_i;
    assign addr_ok     = (host.wr_addr[2:1] != 2'b11);
`endif

    assign wr_ok = host.wr_en & ~busy_q & addr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
        end else if (wr_ok) begin
            shadow_q[host.wr_addr] <= host.wr_data;
        end
    end

    // Value presented for a parameter index; bit 4 of ndiv never reaches the chip.
    function automatic logic [4:0] pick(input logic [2:0] idx, input logic use_gear);
        logic [2:0] a;
        logic [4:0] v;
        a = idx;
        if (use_gear && idx == 3'd1) a = 3'd6;
        if (use_gear && idx == 3'd2) a = 3'd7;
        v = shadow_q[a];
        if (idx == 3'd0) v[4] = 1'b0;
        return v;
    endfunction

    // Sequence launch decisions from the waiting states.
    always_comb begin
        go_full    = 1'b0;
        go_short   = 1'b0;
        short_gear = 1'b0;
        case (state_q)
            ST_IDLE: go_full = host.start;
`ifdef CFG_GEAR_EN
            ST_MONITOR: begin
                go_full    = host.start;
                go_short   = ~host.start & lock_i & lock_hit;
                short_gear = 1'b1;
            end
            ST_LOCKED: begin
                go_full  = host.start;
                go_short = ~host.start & ~lock_i;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            short_q    <= 1'b0;
            gear_seq_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            gear_q     <= 1'b0;
            clr_q      <= 1'b0;
            pgm_q      <= 1'b0;
            sel_q      <= '0;
            val_q      <= '0;
`ifdef CFG_GEAR_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= host.wr_en & ~wr_ok;
`ifdef CFG_GEAR_EN
            lock_cnt_q <= '0;
`endif
            if (go_full) begin
                state_q    <= ST_CLEAR;
                cnt_q      <= C_LD;
                idx_q      <= 3'd0;
                short_q    <= 1'b0;
                gear_seq_q <= 1'b0;
                busy_q     <= 1'b1;
                clr_q      <= 1'b1;
            end else if (go_short) begin
                // No clear: only alpha (1) and beta (2) are rewritten.
                state_q    <= ST_SETUP;
                cnt_q      <= S_LD;
                idx_q      <= 3'd1;
                short_q    <= 1'b1;
                gear_seq_q <= short_gear;
                busy_q     <= 1'b1;
                sel_q      <= 3'd1;
                val_q      <= pick(3'd1, short_gear);
            end else begin
                case (state_q)
                    ST_CLEAR: begin
                        if (cnt_q == 8'd0) begin
                            state_q <= ST_SETUP;
                            cnt_q   <= S_LD;
                            clr_q   <= 1'b0;
                            sel_q   <= 3'd0;
                            val_q   <= pick(3'd0, 1'b0);
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    ST_SETUP: begin
                        if (cnt_q == 8'd0) begin
                            state_q <= ST_PULSE;
                            cnt_q   <= P_LD;
                            pgm_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    ST_PULSE: begin
                        if (cnt_q == 8'd0) begin
                            state_q <= ST_HOLD;
                            cnt_q   <= H_LD;
                            pgm_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    ST_HOLD: begin
                        if (cnt_q != 8'd0) begin
                            cnt_q <= cnt_q - 8'd1;
                        end else if (idx_q == (short_q ? 3'd2 : 3'd5)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            gear_q  <= short_q & gear_seq_q;
                            sel_q   <= '0;
                            val_q   <= '0;
                        end else begin
                            // Value sampled here so a write before SETUP entry is seen.
                            state_q <= ST_SETUP;
                            cnt_q   <= S_LD;
                            idx_q   <= idx_q + 3'd1;
                            sel_q   <= idx_q + 3'd1;
                            val_q   <= pick(idx_q + 3'd1, gear_seq_q);
                        end
                    end
                    ST_DONE: begin
`ifdef CFG_GEAR_EN
                        state_q <= (short_q & gear_seq_q) ? ST_LOCKED : ST_MONITOR;
`else
                        state_q <= ST_IDLE;
`endif
                    end
`ifdef CFG_GEAR_EN
                    ST_MONITOR: begin
                        if (lock_i && lock_cnt_q != 16'hFFFF) lock_cnt_q <= lock_cnt_q + 16'd1;
                    end
                    ST_LOCKED: ;
`endif
                    ST_IDLE: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign host.busy   = busy_q;
    assign host.done   = done_q;
    assign host.err    = err_q;
    assign gear_on_o   = gear_q;
    assign clr_o       = clr_q;
    assign pgm_o       = pgm_q;
    assign param_sel_o = sel_q;
    assign pgm_value_o = val_q;

endmodule

// File: doc/adpll_cfg_seq.md
# adpll_cfg_seq

Programming sequencer for the 5-bit ADPLL chip top. It holds a shadow copy of the six loop parameters: ndiv, alpha, beta, dco_offset, dco_thresh and kdco. On request it replays them onto the chip's clr / pgm / param_sel / pgm_value pins with guaranteed setup, pulse and hold spacing, so the top's enable-edge capture registers always latch stable data. An optional gear-shift mode reprograms alpha/beta once the loop reports lock.

## Interface
- SETUP_CYC, 2: cycles param_sel/pgm_value are stable with pgm low before pgm rises (0 treated as 1)
- PULSE_CYC, 2: cycles pgm is held high per parameter (0 treated as 1)
- HOLD_CYC, 1: cycles param_sel/pgm_value are held after pgm falls (0 treated as 1)
- CLR_CYC, 2: cycles clr is high at sequence start (0 treated as 1)
- LOCK_CNT, 16: consecutive lock cycles required before gear shift (CFG_GEAR_EN only)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a full programming sequence
- wr_en  in  1  shadow register write strobe
- wr_addr  in  3  shadow index: 0 ndiv, 1 alpha, 2 beta, 3 dco_offset, 4 dco_thresh, 5 kdco, 6 alpha_gear, 7 beta_gear
- wr_data  in  5  shadow write data
- lock  in  1  loop lock indication, level
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at the end of any sequence
- err  out  1  one-cycle pulse on a rejected write
- gear_on  out  1  gear (post-lock) coefficients currently programmed
- clr_out  out  1  drives chip clr
- pgm_out  out  1  drives chip pgm
- param_sel_out  out  3  drives chip param_sel
- pgm_value_out  out  5  drives chip pgm_value

## Operation
- Shadow registers are 8 × 5 bits. A write is accepted only when wr_en=1 and busy=0.
- A write while busy=1 is dropped and pulses err.
- Index 0 is stored as 5 bits, but bit 4 is driven as 0 on pgm_value_out.
- FSM states: IDLE, CLEAR, SETUP, PULSE, HOLD, DONE; with CFG_GEAR_EN also MONITOR and LOCKED.
- IDLE: waits for start=1.
- CLEAR: clr_out=1 for CLR_CYC cycles, with pgm_out=0.
- SETUP: param_sel_out=idx and pgm_value_out=shadow value; pgm_out=0 for SETUP_CYC cycles.
- PULSE: pgm_out=1 for PULSE_CYC cycles; sel/value unchanged.
- HOLD: pgm_out=0 for HOLD_CYC cycles; sel/value unchanged.
- After HOLD: advance to the next idx, or go to DONE after the last one.
- A full sequence programs idx 0,1,2,3,4,5 in order.
- DONE: done=1 for one cycle, then IDLE (or MONITOR with CFG_GEAR_EN).
- In IDLE, clr_out, pgm_out, param_sel_out and pgm_value_out are all 0.
- start while busy=1 is ignored.

## Timing
- Reset (next edge with rst=1): all outputs 0, FSM to IDLE, all counters 0, all shadow registers 0.
- Reset mid-sequence aborts immediately; pgm_out falls on that same edge.
- Latency: start sampled high at edge t0 → clr_out=1 and busy=1 from cycle t0+1.
- Full sequence: busy lasts CLR_CYC + 6·(S+P+H) cycles, where S/P/H are the clamped setup/pulse/hold counts.
- done is asserted in the cycle after the last HOLD, with busy=0 in that cycle.
- Defaults: busy is high for 32 cycles; done is at t0+33.
- pgm_out rises exactly S cycles after param_sel_out/pgm_value_out change.
- pgm_value_out and param_sel_out never change while pgm_out=1, nor within H cycles after pgm_out falls.
- Consecutive parameters are separated by at least S+H cycles with pgm_out=0.
- start and wr_en in the same cycle in IDLE: the write is accepted and the sequence starts.
  - The written value is used, because a shadow value is sampled at its SETUP entry.

## Configuration
- Macro CFG_GEAR_EN, defined:
  - After DONE the FSM enters MONITOR. A saturating counter increments each cycle lock=1 and clears when lock=0.
  - When the counter reaches LOCK_CNT, a short sequence runs: no CLEAR, idx 1 value shadow[6], then idx 2 value shadow[7]. busy is high for 2·(S+P+H) cycles.
  - Then done pulses, gear_on=1, and the FSM enters LOCKED.
  - In LOCKED, lock=0 triggers a short sequence restoring shadow[1] and shadow[2]. Then done pulses, gear_on=0, the counter clears and the FSM returns to MONITOR.
  - start in MONITOR/LOCKED runs a full sequence, with gear_on=0 at its DONE.
- Macro CFG_GEAR_EN, not defined:
  - No MONITOR/LOCKED states; lock is ignored and gear_on is tied 0.
  - Writes to addr 6/7 are dropped and pulse err.

## Test plan
- Write 0..5 with values 5,3,2,10,20,7, pulse start → clr_out high for 2 cycles, then six pgm_out pulses each 2 cycles wide with param_sel_out 0..5 and matching values; done at t0+33.
- Write ndiv=5'h1F → pgm_value_out=5'h0F during idx 0.
- wr_en during busy → err pulses 1 cycle and the shadow is unchanged (checked by a second sequence); start during busy → no restart, done still at t0+33.
- rst asserted during PULSE of idx 3 → all outputs 0 at the next edge; a later start replays from idx 0 with all values 0.
- CFG_GEAR_EN, lock=1 for 16 cycles after DONE → alpha=shadow[6], beta=shadow[7] programmed, no clr, gear_on=1; lock dropped → shadow[1]/[2] restored, gear_on=0.
- CFG_GEAR_EN, lock=1 for 15 cycles then 0 for 1 → no gear sequence; counter restarts.
